// File: rtl/slink_clk_switch_ctrl.sv
// Link clock switch sequencer: brings up the PHY PLL and moves the
// link clock between refclk and phy_clk without running on an unlocked PLL.
module slink_clk_switch_ctrl #(
   parameter int LOCK_TIMEOUT    = 1024,
   parameter int SETTLE_CYCLES   = 64,
   parameter int MUX_WAIT_CYCLES = 8,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       phy_clk_req,
   input  logic       phy_pll_lock,
   input  logic       lock_lost_clr,
   output logic       phy_pll_en,
   output logic       use_phy_clk,
   output logic       phy_clk_active,
   output logic       lock_err,
   output logic       lock_lost,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_SETTLE    = 3'd2,
      S_MUX_WAIT  = 3'd3,
      S_ACTIVE    = 3'd4,
      S_REVERT    = 3'd5,
      S_ERROR     = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MUX_LAST    = CNT_W'(MUX_WAIT_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             sync1_q;
   logic             lock_s;
   logic             lock_lost_d;
   logic             pll_en_d;
   logic             use_d;
   logic             active_d;
   logic             err_d;

   // Two-flop synchronizer for the asynchronous PLL lock
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync1_q <= phy_pll_lock;
         lock_s  <= sync1_q;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (phy_clk_req) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (!phy_clk_req) begin
               state_d = S_IDLE;
            end else if (lock_s) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (!phy_clk_req) begin
               state_d = S_IDLE;
            end else if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_MUX_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_MUX_WAIT: begin
            if (!phy_clk_req || !lock_s) begin
               state_d = S_REVERT;
               cnt_d   = '0;
            end else if (cnt_q == MUX_LAST) begin
               state_d = S_ACTIVE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ACTIVE: begin
            if (!phy_clk_req || !lock_s) begin
               state_d = S_REVERT;
               cnt_d   = '0;
            end
         end
         S_REVERT: begin
            if (cnt_q == MUX_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ERROR: begin
            if (!phy_clk_req) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the next state, so registered outputs track state
   always_comb begin
      pll_en_d = state_d inside {S_WAIT_LOCK, S_SETTLE, S_MUX_WAIT,
                                 S_ACTIVE, S_REVERT};
      use_d    = state_d inside {S_MUX_WAIT, S_ACTIVE};
      active_d = (state_d == S_ACTIVE);
      err_d    = (state_d == S_ERROR);
   end

   // Sticky lock-lost flag; a new loss beats a simultaneous clear
   always_comb begin
      lock_lost_d = lock_lost;
      if (lock_lost_clr) begin
         lock_lost_d = 1'b0;
      end
      if ((state_q == S_MUX_WAIT || state_q == S_ACTIVE) && !lock_s) begin
         lock_lost_d = 1'b1;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         phy_pll_en     <= 1'b0;
         use_phy_clk    <= 1'b0;
         phy_clk_active <= 1'b0;
         lock_err       <= 1'b0;
         lock_lost      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         phy_pll_en     <= pll_en_d;
         use_phy_clk    <= use_d;
         phy_clk_active <= active_d;
         lock_err       <= err_d;
         lock_lost      <= lock_lost_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_slink_clk_switch_ctrl.sv
// Directed bench for slink_clk_switch_ctrl: a vector table of
// {inputs, cycles, expected outputs} plus hand-written timing sequences.
module tb_slink_clk_switch_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       phy_clk_req;
   logic       phy_pll_lock;
   logic       lock_lost_clr;
   logic       phy_pll_en;
   logic       use_phy_clk;
   logic       phy_clk_active;
   logic       lock_err;
   logic       lock_lost;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   slink_clk_switch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .phy_clk_req    (phy_clk_req),
      .phy_pll_lock   (phy_pll_lock),
      .lock_lost_clr  (lock_lost_clr),
      .phy_pll_en     (phy_pll_en),
      .use_phy_clk    (use_phy_clk),
      .phy_clk_active (phy_clk_active),
      .lock_err       (lock_err),
      .lock_lost      (lock_lost),
      .state          (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       rst;
      bit       req;
      bit       lock;
      bit       clr;
      int       n;
      bit [7:0] exp;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t v(bit rst, bit req, bit lock, bit clr, int n,
                              bit [2:0] st, bit pll, bit use_c,
                              bit act, bit err, bit lost);
      vec_t r;
      r.rst  = rst;
      r.req  = req;
      r.lock = lock;
      r.clr  = clr;
      r.n    = n;
      r.exp  = {st, pll, use_c, act, err, lost};
      return r;
   endfunction

   function automatic bit [7:0] outs();
      return {state, phy_pll_en, use_phy_clk, phy_clk_active,
              lock_err, lock_lost};
   endfunction

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      reset         = 1'b1;
      phy_clk_req   = 1'b0;
      phy_pll_lock  = 1'b0;
      lock_lost_clr = 1'b0;

      // reset, lock timeout, ERROR hold/exit
      vq.push_back(v(1, 0, 0, 0,    2, 0, 0, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 0, 0,    1, 1, 1, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 0, 0, 1023, 1, 1, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 0, 0,    1, 6, 0, 0, 0, 1, 0));
      vq.push_back(v(0, 1, 0, 0,   20, 6, 0, 0, 0, 1, 0));
      vq.push_back(v(0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0));
      // bring-up with stable lock, then lock loss in ACTIVE
      vq.push_back(v(0, 0, 1, 0,    3, 0, 0, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    1, 1, 1, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    1, 2, 1, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,   63, 2, 1, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    1, 3, 1, 1, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    7, 3, 1, 1, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    1, 4, 1, 1, 1, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    5, 4, 1, 1, 1, 0, 0));
      vq.push_back(v(0, 1, 0, 0,    2, 4, 1, 1, 1, 0, 0));
      vq.push_back(v(0, 1, 0, 0,    1, 5, 1, 0, 0, 0, 1));
      vq.push_back(v(0, 1, 0, 0,    7, 5, 1, 0, 0, 0, 1));
      vq.push_back(v(0, 1, 0, 0,    1, 0, 0, 0, 0, 0, 1));
      vq.push_back(v(0, 0, 0, 0,    3, 0, 0, 0, 0, 0, 1));
      vq.push_back(v(0, 0, 0, 1,    1, 0, 0, 0, 0, 0, 0));
      // set beats clear in the same cycle
      vq.push_back(v(0, 0, 1, 0,    3, 0, 0, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    1, 1, 1, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    1, 2, 1, 0, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,   64, 3, 1, 1, 0, 0, 0));
      vq.push_back(v(0, 1, 1, 0,    8, 4, 1, 1, 1, 0, 0));
      vq.push_back(v(0, 1, 0, 1,    2, 4, 1, 1, 1, 0, 0));
      vq.push_back(v(0, 1, 0, 1,    1, 5, 1, 0, 0, 0, 1));
      vq.push_back(v(0, 1, 1, 0,    7, 5, 1, 0, 0, 0, 1));
      vq.push_back(v(0, 1, 1, 0,    1, 0, 0, 0, 0, 0, 1));
      // back to ACTIVE with lock_lost set, then a 1-cycle reset
      vq.push_back(v(0, 1, 1, 0,    1, 1, 1, 0, 0, 0, 1));
      vq.push_back(v(0, 1, 1, 0,    1, 2, 1, 0, 0, 0, 1));
      vq.push_back(v(0, 1, 1, 0,   64, 3, 1, 1, 0, 0, 1));
      vq.push_back(v(0, 1, 1, 0,    8, 4, 1, 1, 1, 0, 1));
      vq.push_back(v(1, 1, 1, 0,    1, 0, 0, 0, 0, 0, 0));

      foreach (vq[i]) begin
         reset         = vq[i].rst;
         phy_clk_req   = vq[i].req;
         phy_pll_lock  = vq[i].lock;
         lock_lost_clr = vq[i].clr;
         tick(vq[i].n);
         chk($sformatf("vec%0d", i), int'(outs()), int'(vq[i].exp));
      end

      // lock arrives 10 cycles after req; measure switch timing
      reset         = 1'b0;
      phy_clk_req   = 1'b0;
      phy_pll_lock  = 1'b0;
      lock_lost_clr = 1'b0;
      tick(3);
      chk("t1_idle", int'(outs()), 0);
      phy_clk_req = 1'b1;
      tick(10);
      chk("t1_wait", int'(state), 1);
      phy_pll_lock = 1'b1;
      seen = 1'b0;
      n = 0;
      while (state != 3'd2 && n < 20) begin
         tick(1);
         n++;
         seen |= lock_err;
      end
      chk("t1_settle", int'(state), 2);
      n = 0;
      while (!use_phy_clk && n < 200) begin
         tick(1);
         n++;
         seen |= lock_err;
      end
      chk("t1_use_delay", n, 64);
      n = 0;
      while (!phy_clk_active && n < 50) begin
         tick(1);
         n++;
         seen |= lock_err;
      end
      chk("t1_active_delay", n, 8);
      chk("t1_no_err", int'(seen), 0);

      // req dropped at MUX_WAIT cnt=3, re-raised inside REVERT
      phy_clk_req = 1'b0;
      tick(9);
      chk("t5_idle", int'(outs()), 0);
      phy_clk_req = 1'b1;
      tick(2);
      chk("t5_settle", int'(state), 2);
      tick(64);
      chk("t5_mux", int'({state, use_phy_clk}), int'({3'd3, 1'b1}));
      tick(3);
      phy_clk_req = 1'b0;
      tick(1);
      chk("t5_revert", int'({state, phy_pll_en, use_phy_clk}),
          int'({3'd5, 1'b1, 1'b0}));
      tick(1);
      phy_clk_req = 1'b1;
      tick(6);
      chk("t5_revert_hold", int'(state), 5);
      tick(1);
      chk("t5_idle_once", int'(state), 0);
      tick(1);
      chk("t5_rewait", int'(state), 1);

      // 3-cycle lock glitch at SETTLE cnt=40
      phy_clk_req = 1'b0;
      tick(1);
      chk("t3_idle", int'(state), 0);
      phy_clk_req = 1'b1;
      tick(2);
      chk("t3_settle0", int'(state), 2);
      tick(40);
      phy_pll_lock = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         seen |= use_phy_clk;
      end
      chk("t3_back_wait", int'(state), 1);
      phy_pll_lock = 1'b1;
      n = 0;
      while (state != 3'd2 && n < 20) begin
         tick(1);
         n++;
         seen |= use_phy_clk;
      end
      chk("t3_resettle", int'(state), 2);
      n = 0;
      while (state != 3'd3 && n < 200) begin
         tick(1);
         n++;
         if (state != 3'd3) seen |= use_phy_clk;
      end
      chk("t3_full_settle", n, 64);
      chk("t3_use_low", int'(seen), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
